uart_frame_streamer: RTL

UART_FRAME_STREAMER -- requirements
Module: uart_frame_streamer

---
 rtl/uart_frame_pkg.sv | 29 ++
 rtl/uart_frame_tick.sv | 33 +++
 rtl/uart_frame_streamer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types, ASCII constants and helpers for the UART frame streamer.
// Checksum states are reached only when UART_FRAME_CSUM_EN is defined.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    CSUM_HI,
    CSUM_LO,
    DONE
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(
    input logic [3:0] nib
  );
    if (nib < 4'd10) begin
      return ASCII_0 + {4'd0, nib};
    end
    return ASCII_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_frame_tick.sv
// Free-running period tick: one-cycle pulse every
// CLK_FREQ_HZ*PERIOD_MS/1000 clocks, counting from reset.
module uart_frame_tick #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int PERIOD_MS   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam longint CYC_RAW =
    (64'(CLK_FREQ_HZ) * 64'(PERIOD_MS)) / 1000;
  localparam longint CYC = (CYC_RAW < 1) ? 1 : CYC_RAW;
  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Period counter, wraps on the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_streamer.sv
// Streams ROM message frames to a UART with an ASCII BCD frame counter.
// Define UART_FRAME_CSUM_EN to append a two-char hex XOR checksum.
module uart_frame_streamer
  import uart_frame_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int PERIOD_MS   = 1000,
  parameter int MSG_LEN     = 15,
  parameter int NUM_SRC     = 2,
  parameter int CNT_POS     = 12,
  parameter int CNT_DIGITS  = 2,
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SRC_W-1:0]       src_sel,
  output logic [SRC_W+IDX_W-1:0] rom_addr,
  input  logic [7:0]             rom_data,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic                   overrun
);

  localparam int DW = (CNT_DIGITS > 0) ? CNT_DIGITS : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  if (MSG_LEN == 0 || CNT_POS + CNT_DIGITS > MSG_LEN) begin : g_bad_cfg
    $error("uart_frame_streamer: counter field outside message");
  end

  state_t            state;
  state_t            nxt;
  logic              tick;
  logic              req;
  logic              last;
  logic [SRC_W-1:0]  src_q;
  logic [IDX_W-1:0]  idx;
  logic [4*DW-1:0]   bcd;
  logic [4*DW-1:0]   bcd_inc;
  logic [7:0]        load_byte;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]        csum;
  logic [7:0]        csum_nxt;
`endif

  uart_frame_tick #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .PERIOD_MS   (PERIOD_MS)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign req  = tick | start;
  assign last = (idx == LAST_IDX);
  assign busy = (state != IDLE);
`ifdef UART_FRAME_CSUM_EN
  assign csum_nxt = csum ^ tx_data;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (req) nxt = FETCH;
      FETCH: nxt = LOAD;
      LOAD:  nxt = SEND;
      SEND: begin
        if (tx_ready) begin
          if (!last) nxt = FETCH;
`ifdef UART_FRAME_CSUM_EN
          else nxt = CSUM_HI;
`else
          else nxt = DONE;
`endif
        end
      end
`ifdef UART_FRAME_CSUM_EN
      CSUM_HI: if (tx_ready) nxt = CSUM_LO;
      CSUM_LO: if (tx_ready) nxt = DONE;
`endif
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Byte to load: ROM data, or a counter digit inside the field
  always_comb begin
    load_byte = rom_data;
    for (int d = 0; d < CNT_DIGITS; d++) begin
      if (int'(idx) == CNT_POS + CNT_DIGITS - 1 - d) begin
        load_byte = ASCII_0 + {4'd0, bcd[4*d +: 4]};
      end
    end
  end

  // Decimal increment with wrap of the all-nines value
  always_comb begin
    logic carry;
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int d = 0; d < DW; d++) begin
      if (carry) begin
        if (bcd[4*d +: 4] == 4'd9) begin
          bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          bcd_inc[4*d +: 4] = bcd[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Datapath: launch capture, ROM addressing, tx handshake, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      idx       <= '0;
      rom_addr  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      bcd       <= '0;
`ifdef UART_FRAME_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (req && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (req) begin
            src_q    <= src_sel;
            idx      <= '0;
            rom_addr <= {src_sel, IDX_W'(0)};
`ifdef UART_FRAME_CSUM_EN
            csum     <= '0;
`endif
          end
        end
        LOAD: begin
          tx_data  <= load_byte;
          tx_valid <= 1'b1;
        end
        SEND: begin
          if (tx_ready) begin
`ifdef UART_FRAME_CSUM_EN
            csum <= csum_nxt;
`endif
            if (last) begin
`ifdef UART_FRAME_CSUM_EN
              tx_data  <= hex_ascii(csum_nxt[7:4]);
`else
              tx_valid <= 1'b0;
`endif
            end else begin
              idx      <= idx + IDX_W'(1);
              rom_addr <= {src_q, idx + IDX_W'(1)};
              tx_valid <= 1'b0;
            end
          end
        end
`ifdef UART_FRAME_CSUM_EN
        CSUM_HI: begin
          if (tx_ready) tx_data <= hex_ascii(csum[3:0]);
        end
        CSUM_LO: begin
          if (tx_ready) tx_valid <= 1'b0;
        end
`endif
        DONE: begin
          bcd       <= bcd_inc;
          frame_cnt <= frame_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
